// File: rtl/ivs_pi_rr_mgr_if.sv
// ---------------------------------------------------------------------------
// ivs_pi_rr_mgr_if
// Descriptor-fetch DMA read port between the processing-instruction manager
// and the DMA engine.
//   dma_cmd_fetch_req  read-address valid          (master -> slave)
//   dma_ar_rdy         read-address accept         (slave  -> master)
//   dma_ar_base        read byte address, 32 bits  (master -> slave)
//   dma_ar_len         burst length minus one      (master -> slave)
//   dma_rdata_vld      read beat valid             (slave  -> master)
//   dma_rdata_last     last beat of the burst      (slave  -> master)
//   dma_rdata          64-bit read data            (slave  -> master)
//   dma_rdata_rdy      read beat ready             (master -> slave)
// ---------------------------------------------------------------------------
interface ivs_pi_rr_mgr_if;
  logic        dma_cmd_fetch_req;
  logic        dma_ar_rdy;
  logic [31:0] dma_ar_base;
  logic [4:0]  dma_ar_len;
  logic        dma_rdata_vld;
  logic        dma_rdata_last;
  logic [63:0] dma_rdata;
  logic        dma_rdata_rdy;

  modport master (
    output dma_cmd_fetch_req, dma_ar_base, dma_ar_len, dma_rdata_rdy,
    input  dma_ar_rdy, dma_rdata_vld, dma_rdata_last, dma_rdata
  );

  modport slave (
    input  dma_cmd_fetch_req, dma_ar_base, dma_ar_len, dma_rdata_rdy,
    output dma_ar_rdy, dma_rdata_vld, dma_rdata_last, dma_rdata
  );
endinterface

// File: rtl/ivs_pi_rr_mgr.sv
// ---------------------------------------------------------------------------
// ivs_pi_rr_mgr
// Round-robin processing-instruction manager. Watches per-channel doorbells,
// grants one channel at a time, fetches its command descriptor over the DMA
// read port, hands the decoded frame parameters to the engine and clears
// the doorbell once the engine reports completion.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   dma_ci                doorbell level per channel
//   dma_cmd_base          descriptor table base address
//   bus (master)          descriptor read port (see ivs_pi_rr_mgr_if)
//   frm_*                 decoded frame parameters of the granted channel
//   slot_ch               channel currently granted
//   slot_load_par         pulse: frm_* updated this cycle
//   slot_start            pulse: wake the engine
//   slot_pro_done         engine completion (honoured only while waiting)
//   ci_clr                one-hot doorbell clear pulse
//   desc_err              pulse: burst ended at the wrong beat
//   busy                  FSM not idle
// ---------------------------------------------------------------------------
module ivs_pi_rr_mgr #(
  parameter int NUM_CH     = 32,
  parameter int CH_W       = 5,
  parameter int DESC_BEATS = 4,
  parameter int DESC_SH    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   dma_ci,
  input  logic [31:0]         dma_cmd_base,
  ivs_pi_rr_mgr_if.master     bus,
  output logic [2:0]          frm_mode,
  output logic [2:0]          frm_format,
  output logic [15:0]         frm_line_stride,
  output logic [15:0]         frm_width,
  output logic [15:0]         frm_height,
  output logic [15:0]         frm_x_steps,
  output logic [15:0]         frm_y_steps,
  output logic [15:0]         frm_x_stride,
  output logic [15:0]         frm_y_stride,
  output logic [31:0]         frm_i_base,
  output logic [31:0]         frm_o_base,
  output logic [CH_W-1:0]     slot_ch,
  output logic                slot_load_par,
  output logic                slot_start,
  input  logic                slot_pro_done,
  output logic [NUM_CH-1:0]   ci_clr,
  output logic                desc_err,
  output logic                busy
);

  localparam int BC_W = $clog2(DESC_BEATS);
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(DESC_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SEL = 3'd1, S_AR = 3'd2, S_RD = 3'd3,
    S_LOAD = 3'd4, S_WAKE = 3'd5, S_WAIT = 3'd6, S_CLR = 3'd7
  } state_t;

  typedef struct packed {
    logic [2:0]  mode;
    logic [2:0]  format;
    logic [15:0] line_stride;
    logic [15:0] width;
    logic [15:0] height;
    logic [15:0] x_steps;
    logic [15:0] y_steps;
    logic [15:0] x_stride;
    logic [15:0] y_stride;
    logic [31:0] i_base;
    logic [31:0] o_base;
  } frm_t;

  state_t          state_r, state_s;
  logic [CH_W-1:0] slot_ch_r, slot_ch_s;
  logic [CH_W-1:0] last_grant_r, last_grant_s;
  logic            err_r, err_s;
  logic [BC_W-1:0] beat_cnt_r, beat_cnt_s;
  frm_t            stg_r, stg_s;
  frm_t            frm_r, frm_s;
  logic            fetch_req_r, rdata_rdy_r, load_par_r, start_r, busy_r, desc_err_r;
  logic [NUM_CH-1:0] ci_clr_r;

  // First requesting channel strictly after 'last', wrapping at NUM_CH.
  function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CH_W-1:0]   last);
    logic [CH_W-1:0] pick;
    logic [CH_W-1:0] idx_c;
    logic            found;
    int              idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(last) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      else               idx = idx;
      idx_c = CH_W'(idx);
      if (!found && req[idx_c]) begin
        pick  = idx_c;
        found = 1'b1;
      end else begin
        pick  = pick;
        found = found;
      end
    end
    return pick;
  endfunction

  // Next-state, grant, beat capture and descriptor hand-over.
  always_comb begin
    state_s      = state_r;
    slot_ch_s    = slot_ch_r;
    last_grant_s = last_grant_r;
    err_s        = err_r;
    beat_cnt_s   = beat_cnt_r;
    stg_s        = stg_r;
    frm_s        = frm_r;
    case (state_r)
      S_IDLE: begin
        if (|dma_ci) state_s = S_SEL;
        else         state_s = S_IDLE;
      end
      S_SEL: begin
        if (|dma_ci) begin
          slot_ch_s = rr_pick(dma_ci, last_grant_r);
          state_s   = S_AR;
        end else begin
          state_s   = S_IDLE;
        end
      end
      S_AR: begin
        beat_cnt_s = BC_W'(0);
        if (bus.dma_ar_rdy) state_s = S_RD;
        else                state_s = S_AR;
      end
      S_RD: begin
        if (bus.dma_rdata_vld) begin
          case (beat_cnt_r)
            BC_W'(0): begin
              stg_s.mode        = bus.dma_rdata[2:0];
              stg_s.format      = bus.dma_rdata[6:4];
              stg_s.line_stride = bus.dma_rdata[31:16];
              stg_s.width       = bus.dma_rdata[47:32];
              stg_s.height      = bus.dma_rdata[63:48];
            end
            BC_W'(1): begin
              stg_s.x_steps  = bus.dma_rdata[15:0];
              stg_s.y_steps  = bus.dma_rdata[31:16];
              stg_s.x_stride = bus.dma_rdata[47:32];
              stg_s.y_stride = bus.dma_rdata[63:48];
            end
            BC_W'(2): begin
              stg_s.i_base = bus.dma_rdata[31:0];
              stg_s.o_base = bus.dma_rdata[63:32];
            end
            default: stg_s = stg_r;
          endcase
          if (beat_cnt_r != LAST_BEAT) beat_cnt_s = beat_cnt_r + BC_W'(1);
          else                         beat_cnt_s = beat_cnt_r;
          if (bus.dma_rdata_last) begin
            // stg_s already holds the beat arriving on this edge
            if (beat_cnt_r == LAST_BEAT) begin
              frm_s   = stg_s;
              state_s = S_LOAD;
            end else begin
              err_s   = 1'b1;
              state_s = S_CLR;
            end
          end else begin
            state_s = S_RD;
          end
        end else begin
          state_s = S_RD;
        end
      end
      S_LOAD: state_s = S_WAKE;
      S_WAKE: state_s = S_WAIT;
      S_WAIT: begin
        if (slot_pro_done) state_s = S_CLR;
        else               state_s = S_WAIT;
      end
      S_CLR: begin
        last_grant_s = slot_ch_r;
        err_s        = 1'b0;
        state_s      = S_IDLE;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State and datapath registers; outputs are decoded from the next state
  // so every pulse comes straight out of a flop in the cycle of that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      slot_ch_r    <= CH_W'(0);
      last_grant_r <= CH_W'(NUM_CH - 1);
      err_r        <= 1'b0;
      beat_cnt_r   <= BC_W'(0);
      stg_r        <= '0;
      frm_r        <= '0;
      fetch_req_r  <= 1'b0;
      rdata_rdy_r  <= 1'b0;
      load_par_r   <= 1'b0;
      start_r      <= 1'b0;
      busy_r       <= 1'b0;
      desc_err_r   <= 1'b0;
      ci_clr_r     <= {NUM_CH{1'b0}};
    end else begin
      state_r      <= state_s;
      slot_ch_r    <= slot_ch_s;
      last_grant_r <= last_grant_s;
      err_r        <= err_s;
      beat_cnt_r   <= beat_cnt_s;
      stg_r        <= stg_s;
      frm_r        <= frm_s;
      fetch_req_r  <= (state_s == S_AR);
      rdata_rdy_r  <= (state_s == S_RD);
      load_par_r   <= (state_s == S_LOAD);
      start_r      <= (state_s == S_WAKE);
      busy_r       <= (state_s != S_IDLE);
      desc_err_r   <= (state_s == S_CLR) && err_s;
      ci_clr_r     <= (state_s == S_CLR) ? ({{(NUM_CH-1){1'b0}}, 1'b1} << slot_ch_s)
                                         : {NUM_CH{1'b0}};
    end
  end

  assign bus.dma_cmd_fetch_req = fetch_req_r;
  assign bus.dma_rdata_rdy     = rdata_rdy_r;
  assign bus.dma_ar_len        = 5'(DESC_BEATS - 1);
  assign bus.dma_ar_base       = dma_cmd_base + ({{(32-CH_W){1'b0}}, slot_ch_r} << DESC_SH);

  assign frm_mode        = frm_r.mode;
  assign frm_format      = frm_r.format;
  assign frm_line_stride = frm_r.line_stride;
  assign frm_width       = frm_r.width;
  assign frm_height      = frm_r.height;
  assign frm_x_steps     = frm_r.x_steps;
  assign frm_y_steps     = frm_r.y_steps;
  assign frm_x_stride    = frm_r.x_stride;
  assign frm_y_stride    = frm_r.y_stride;
  assign frm_i_base      = frm_r.i_base;
  assign frm_o_base      = frm_r.o_base;
  assign slot_ch         = slot_ch_r;
  assign slot_load_par   = load_par_r;
  assign slot_start      = start_r;
  assign ci_clr          = ci_clr_r;
  assign desc_err        = desc_err_r;
  assign busy            = busy_r;

endmodule
